// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL RESETB, qualifies LOCK and releases the system reset after a stable lock and hold-off.
module pll_lock_sequencer #(
    parameter int PLL_RESET_CYCLES    = 4,
    parameter int LOCK_STABLE_CYCLES  = 8,
    parameter int POST_LOCK_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       i_n_reset,
    input  logic       i_is_locked,
    input  logic       i_restart_req,
    output logic       o_pll_reset_b,
    output logic       o_sys_reset_n,
    output logic       o_running,
    output logic       o_failed,
    output logic [7:0] o_loss_count,
    output logic [3:0] o_retry_count
);
    localparam int TMAX_A = PLL_RESET_CYCLES > POST_LOCK_CYCLES ? PLL_RESET_CYCLES : POST_LOCK_CYCLES;
    localparam int TMAX   = TMAX_A > LOCK_TIMEOUT_CYCLES ? TMAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int SW     = $clog2(LOCK_STABLE_CYCLES + 1);

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, HOLD, RUN, FAIL} state_t;

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [TW-1:0]   r_timer;
    logic [SW-1:0]   r_stable;
    logic            w_lock;

    assign w_lock = r_sync[1];

    always_ff @(posedge clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state       <= PLL_RST;
            r_sync        <= '0;
            r_timer       <= '0;
            r_stable      <= '0;
            o_pll_reset_b <= 1'b0;
            o_sys_reset_n <= 1'b0;
            o_running     <= 1'b0;
            o_failed      <= 1'b0;
            o_loss_count  <= '0;
            o_retry_count <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_is_locked};
            r_timer <= r_timer + TW'(1);
            if (i_restart_req) begin
                r_state       <= PLL_RST;
                r_timer       <= '0;
                r_stable      <= '0;
                o_pll_reset_b <= 1'b0;
                o_sys_reset_n <= 1'b0;
                o_running     <= 1'b0;
                o_failed      <= 1'b0;
                o_retry_count <= '0;
            end else begin
                case (r_state)
                    PLL_RST: if (r_timer == TW'(PLL_RESET_CYCLES - 1)) begin
                        r_state       <= WAIT_LOCK;
                        r_timer       <= '0;
                        r_stable      <= '0;
                        o_pll_reset_b <= 1'b1;
                    end
                    WAIT_LOCK: begin
                        r_stable <= w_lock ? r_stable + SW'(1) : '0;
                        // a completed stable run wins over a timeout on the same edge
                        if (w_lock && r_stable == SW'(LOCK_STABLE_CYCLES - 1)) begin
                            r_state <= HOLD;
                            r_timer <= '0;
                        end else if (r_timer == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                            r_timer       <= '0;
                            o_pll_reset_b <= 1'b0;
                            o_retry_count <= o_retry_count + 4'd1;
                            if (o_retry_count + 4'd1 == 4'(MAX_RETRIES)) begin
                                r_state  <= FAIL;
                                o_failed <= 1'b1;
                            end else begin
                                r_state <= PLL_RST;
                            end
                        end
                    end
                    HOLD: if (!w_lock) begin
                        r_state       <= PLL_RST;
                        r_timer       <= '0;
                        o_pll_reset_b <= 1'b0;
                    end else if (r_timer == TW'(POST_LOCK_CYCLES - 1)) begin
                        r_state       <= RUN;
                        r_timer       <= '0;
                        o_sys_reset_n <= 1'b1;
                        o_running     <= 1'b1;
                        o_retry_count <= '0;
                    end
                    RUN: if (!w_lock) begin
                        r_state       <= PLL_RST;
                        r_timer       <= '0;
                        o_pll_reset_b <= 1'b0;
                        o_sys_reset_n <= 1'b0;
                        o_running     <= 1'b0;
                        o_loss_count  <= o_loss_count == 8'hff ? o_loss_count : o_loss_count + 8'd1;
                    end
                    FAIL: r_timer <= '0;
                    default: r_state <= PLL_RST;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed and randomized checks of pll_lock_sequencer against a phase/age reference model.
module tb_pll_lock_sequencer;
    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int POST = 16;
    localparam int LTC  = 64;
    localparam int MAXR = 3;
    localparam int P_RST = 0, P_WAIT = 1, P_HOLD = 2, P_RUN = 3, P_FAIL = 4;

    logic       clk;
    logic       n_reset;
    logic       is_locked;
    logic       restart_req;
    logic       o_pll_reset_b;
    logic       o_sys_reset_n;
    logic       o_running;
    logic       o_failed;
    logic [7:0] o_loss_count;
    logic [3:0] o_retry_count;

    int errors = 0;
    int checks = 0;
    int lat;
    bit dropped;
    bit fell;
    int prev;
    int seq[$];

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .POST_LOCK_CYCLES(POST),
        .LOCK_TIMEOUT_CYCLES(LTC), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .i_n_reset(n_reset), .i_is_locked(is_locked), .i_restart_req(restart_req),
        .o_pll_reset_b(o_pll_reset_b), .o_sys_reset_n(o_sys_reset_n), .o_running(o_running),
        .o_failed(o_failed), .o_loss_count(o_loss_count), .o_retry_count(o_retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // phase plus edges spent in it; lock_hist holds the raw lock samples still in flight through the synchronizer
    typedef struct packed {
        int phase;
        int age;
        int run;
        int retries;
        int losses;
        bit [1:0] lock_hist;
    } model_t;

    model_t m;

    function automatic model_t step(model_t cur, bit lk, bit rq);
        model_t nx = cur;
        bit ls = cur.lock_hist[1];
        nx.lock_hist = {cur.lock_hist[0], lk};
        nx.age = cur.age + 1;
        if (rq) begin
            nx.phase = P_RST;
            nx.retries = 0;
        end else begin
            case (cur.phase)
                P_RST: if (nx.age == PRC) nx.phase = P_WAIT;
                P_WAIT: begin
                    nx.run = ls ? cur.run + 1 : 0;
                    if (nx.run == LSC) nx.phase = P_HOLD;
                    else if (nx.age == LTC) begin
                        nx.retries = cur.retries + 1;
                        nx.phase = nx.retries == MAXR ? P_FAIL : P_RST;
                    end
                end
                P_HOLD: if (!ls) nx.phase = P_RST;
                        else if (nx.age == POST) begin
                            nx.phase = P_RUN;
                            nx.retries = 0;
                        end
                P_RUN: if (!ls) begin
                    nx.phase = P_RST;
                    nx.losses = cur.losses < 255 ? cur.losses + 1 : 255;
                end
                default: ;
            endcase
        end
        if (rq || nx.phase != cur.phase) begin
            nx.age = 0;
            nx.run = 0;
        end
        return nx;
    endfunction

    always @(posedge clk or negedge n_reset)
        if (!n_reset) m <= '0;
        else m <= step(m, is_locked, restart_req);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_pllResetB", o_pll_reset_b, m.phase inside {P_WAIT, P_HOLD, P_RUN});
        chk("model_sysResetN", o_sys_reset_n, m.phase == P_RUN);
        chk("model_running", o_running, m.phase == P_RUN);
        chk("model_failed", o_failed, m.phase == P_FAIL);
        chk("model_lossCount", o_loss_count, m.losses);
        chk("model_retryCount", o_retry_count, m.retries);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        n_reset = 1'b0;
        is_locked = 1'b0;
        restart_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pllResetB", o_pll_reset_b, 0);
        chk("rst_sysResetN", o_sys_reset_n, 0);
        chk("rst_running", o_running, 0);
        chk("rst_failed", o_failed, 0);
        chk("rst_lossCount", o_loss_count, 0);
        chk("rst_retryCount", o_retry_count, 0);
        check_model();

        // clean bring-up
        n_reset = 1'b1;
        for (int k = 1; k <= PRC; k++) begin
            tick();
            chk("release_pllResetB", o_pll_reset_b, k == PRC);
        end
        repeat (10 - PRC) tick();
        is_locked = 1'b1;
        lat = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (o_sys_reset_n) begin lat = e; break; end
        end
        chk("bringup_latency", lat, 2 + LSC + POST);
        chk("bringup_running", o_running, 1);
        chk("bringup_lossCount", o_loss_count, 0);

        // lock loss in RUN, isLocked low for 3 sampled edges
        is_locked = 1'b0;
        lat = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (!o_sys_reset_n) begin lat = e; break; end
        end
        is_locked = 1'b1;
        chk("loss_latency", lat, 1 + 2);
        chk("loss_pll_same_edge", o_pll_reset_b, 0);
        chk("loss_running", o_running, 0);
        chk("loss_lossCount", o_loss_count, 1);
        lat = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (o_pll_reset_b) begin lat = e; break; end
        end
        chk("loss_pll_low_cycles", lat, PRC);
        lat = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (o_sys_reset_n) begin lat = e; break; end
        end
        chk("relock_running", o_running, 1);

        // restart from RUN is not a loss; then glitchy lock
        is_locked = 1'b0;
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("restart_keeps_loss", o_loss_count, 1);
        chk("restart_sysResetN", o_sys_reset_n, 0);
        for (int e = 1; e <= 20 && !o_pll_reset_b; e++) tick();
        chk("glitch_in_wait", o_pll_reset_b, 1);
        lat = 0;
        dropped = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            is_locked = (e != 6);
            tick();
            if (!o_pll_reset_b) dropped = 1'b1;
            if (o_sys_reset_n) begin lat = e; break; end
        end
        chk("glitch_latency", lat, 6 + 2 + LSC + POST);
        chk("glitch_no_pll_pulse", dropped, 0);

        // repeated losses saturate lossCount
        for (int i = 0; i < 300; i++) begin
            int d = $urandom_range(1, 4);
            fell = 1'b0;
            lat = 0;
            for (int e = 1; e <= 120; e++) begin
                is_locked = (e > d);
                tick();
                if (!o_sys_reset_n) fell = 1'b1;
                if (fell && o_sys_reset_n) begin lat = e; break; end
            end
            if (lat == 0) begin
                chk("sat_relock_timeout", lat, 1);
                break;
            end
        end
        chk("sat_lossCount", o_loss_count, 255);

        // timeout and FAIL
        is_locked = 1'b0;
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        prev = o_retry_count;
        lat = 0;
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (int'(o_retry_count) != prev) begin
                prev = o_retry_count;
                seq.push_back(prev);
            end
            if (o_failed) begin lat = e; break; end
        end
        chk("fail_latency", lat, MAXR * (PRC + LTC));
        chk("retry_steps", seq.size(), MAXR);
        for (int i = 0; i < MAXR; i++) chk("retry_step_value", i < seq.size() ? seq[i] : -1, i + 1);
        repeat (20) begin
            is_locked = 1'($urandom_range(0, 1));
            tick();
        end
        chk("fail_stays", o_failed, 1);
        chk("fail_pllResetB", o_pll_reset_b, 0);
        chk("fail_sysResetN", o_sys_reset_n, 0);

        // restart from FAIL
        is_locked = 1'b0;
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("restart_failed", o_failed, 0);
        chk("restart_retryCount", o_retry_count, 0);
        is_locked = 1'b1;
        for (int e = 1; e <= 100 && !o_sys_reset_n; e++) tick();
        chk("restart_bringup", o_running, 1);
        chk("restart_lossCount", o_loss_count, 255);

        // asynchronous reset in HOLD
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        repeat (PRC + LSC + 3) tick();
        chk("hold_pllResetB", o_pll_reset_b, 1);
        chk("hold_sysResetN", o_sys_reset_n, 0);
        #2;
        n_reset = 1'b0;
        #1;
        chk("async_pllResetB", o_pll_reset_b, 0);
        chk("async_lossCount", o_loss_count, 0);
        chk("async_retryCount", o_retry_count, 0);
        chk("async_failed", o_failed, 0);
        check_model();
        repeat (2) tick();
        n_reset = 1'b1;

        // random lock waveforms with occasional restarts
        for (int s = 0; s < 120; s++) begin
            int hi = $urandom_range(1, 60);
            int lo = $urandom_range(1, 8);
            for (int c = 0; c < hi + lo; c++) begin
                is_locked = (c < hi);
                restart_req = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        restart_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
